button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer_pkg.sv | 19 +
 rtl/button_debouncer_filter.sv | 62 ++++++
 rtl/button_debouncer.sv | 103 ++++++++++
 tb/tb_button_debouncer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared types and tick arithmetic for the button debouncer.
// Tick counts are 64-bit so large clock rates times long hold times never overflow.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } btn_state_t;

    function automatic longint ms_to_ticks(input longint freq_hz, input longint ms);
        return (freq_hz / 64'sd1000) * ms;
    endfunction

    function automatic int cnt_width(input longint ticks);
        return (ticks <= 0) ? 1 : $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_filter.sv
// Two-flop synchronizer, polarity normalization (1 = pressed) and a
// stability counter that only accepts a new level after TICKS steady cycles.
module debounce_filter
    import button_debouncer_pkg::*;
#(
    parameter longint TICKS       = 0,
    parameter int     INPUT_LEVEL = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic state
);

    localparam logic IN_LVL = 1'(INPUT_LEVEL);

    logic sync1 = ~IN_LVL;
    logic sync2 = ~IN_LVL;
    logic norm;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= ~IN_LVL;
            sync2 <= ~IN_LVL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign norm = sync2 ~^ IN_LVL;

    generate
        if (TICKS == 0) begin : g_pass
            // Filtering disabled: the second synchronizer flop is the only register stage.
            assign state = norm;
        end else begin : g_filt
            localparam int CW = cnt_width(TICKS);
            localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

            logic [CW-1:0] cnt = '0;
            logic          db  = 1'b0;

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt <= '0;
                    db  <= 1'b0;
                end else if (norm == db) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    db  <= norm;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign state = db;
        end
    endgenerate

endmodule

// File: rtl/button_debouncer.sv
// Debounced button with registered press level, short-press click pulse on
// release and a long-press pulse once the hold time is reached.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int CLK_FREQUENCY          = 100000000,
    parameter int BUTTON_INPUT_LEVEL     = 1,
    parameter int CLICK_OUTPUT_LEVEL     = 1,
    parameter int CLICK_DEBOUNCE_MS      = 10,
    parameter int PRESS_OUTPUT_LEVEL     = 1,
    parameter int LONG_PRESS_DURATION_MS = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic usr_btn,
    output logic click,
    output logic press,
    output logic long_press
);

    localparam longint DB_TICKS = ms_to_ticks(longint'(CLK_FREQUENCY), longint'(CLICK_DEBOUNCE_MS));
    localparam longint LP_TICKS = ms_to_ticks(longint'(CLK_FREQUENCY), longint'(LONG_PRESS_DURATION_MS));
    localparam int     HW       = cnt_width(LP_TICKS);
    localparam logic [HW-1:0] LP_LAST = (LP_TICKS == 0) ? '0 : HW'(LP_TICKS - 1);
    localparam logic CLICK_ON = 1'(CLICK_OUTPUT_LEVEL);
    localparam logic PRESS_ON = 1'(PRESS_OUTPUT_LEVEL);

    logic db;

    debounce_filter #(
        .TICKS       (DB_TICKS),
        .INPUT_LEVEL (BUTTON_INPUT_LEVEL)
    ) u_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (usr_btn),
        .state (db)
    );

    btn_state_t    state_q = IDLE;
    btn_state_t    state_d;
    logic [HW-1:0] hold_q  = '0;
    logic [HW-1:0] hold_d;
    logic          click_d, lp_d, press_d;
    logic          click_r = ~CLICK_ON;
    logic          lp_r    = ~CLICK_ON;
    logic          press_r = ~PRESS_ON;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            click_r <= ~CLICK_ON;
            lp_r    <= ~CLICK_ON;
            press_r <= ~PRESS_ON;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            click_r <= click_d ? CLICK_ON : ~CLICK_ON;
            lp_r    <= lp_d    ? CLICK_ON : ~CLICK_ON;
            press_r <= press_d ? PRESS_ON : ~PRESS_ON;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (db) begin
                    // A zero hold time qualifies as long on the very first pressed cycle.
                    state_d = (LP_TICKS == 0) ? LONG_HELD : PRESSED;
                    hold_d  = '0;
                end
            end
            PRESSED: begin
                // Threshold is checked before release so a tie yields long_press, not click.
                if (hold_q == LP_LAST) begin
                    state_d = LONG_HELD;
                end else if (!db) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            LONG_HELD: begin
                if (!db) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        click_d = (state_q == PRESSED) && (state_d == IDLE);
        lp_d    = (state_q != LONG_HELD) && (state_d == LONG_HELD);
        press_d = (state_d != IDLE);
    end

    assign click      = click_r;
    assign long_press = lp_r;
    assign press      = press_r;

endmodule

// File: tb/tb_button_debouncer.sv
// Three debouncer configurations driven from one logical button, each compared
// every cycle against an event/timestamp model of the debounce and hold rules.
module tb_button_debouncer;

    localparam int FREQ   = 1000000;
    localparam int DBT[3] = '{1000, 1000, 0};
    localparam int LPT[3] = '{5000, 5000, 0};
    localparam bit BIL[3] = '{1'b1, 1'b0, 1'b1};
    localparam bit COL[3] = '{1'b1, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic p = 1'b0;
    logic btn_a = 1'b0, btn_b = 1'b1, btn_c = 1'b0;
    logic click_a, press_a, lp_a;
    logic click_b, press_b, lp_b;
    logic click_c, press_c, lp_c;

    always #5 clk = ~clk;

    button_debouncer #(.CLK_FREQUENCY(FREQ), .BUTTON_INPUT_LEVEL(1), .CLICK_OUTPUT_LEVEL(1),
        .CLICK_DEBOUNCE_MS(1), .PRESS_OUTPUT_LEVEL(1), .LONG_PRESS_DURATION_MS(5)) u_a (
        .clk(clk), .reset(reset), .usr_btn(btn_a), .click(click_a), .press(press_a), .long_press(lp_a));
    button_debouncer #(.CLK_FREQUENCY(FREQ), .BUTTON_INPUT_LEVEL(0), .CLICK_OUTPUT_LEVEL(0),
        .CLICK_DEBOUNCE_MS(1), .PRESS_OUTPUT_LEVEL(1), .LONG_PRESS_DURATION_MS(5)) u_b (
        .clk(clk), .reset(reset), .usr_btn(btn_b), .click(click_b), .press(press_b), .long_press(lp_b));
    button_debouncer #(.CLK_FREQUENCY(FREQ), .BUTTON_INPUT_LEVEL(1), .CLICK_OUTPUT_LEVEL(1),
        .CLICK_DEBOUNCE_MS(0), .PRESS_OUTPUT_LEVEL(1), .LONG_PRESS_DURATION_MS(0)) u_c (
        .clk(clk), .reset(reset), .usr_btn(btn_c), .click(click_c), .press(press_c), .long_press(lp_c));

    int checks = 0;
    int errors = 0;
    int n = 0;

    // model state per configuration
    bit s1[3], s2[3], db[3], prev_seen[3], pressed[3], held_long[3];
    bit e_click[3], e_lp[3], e_press[3];
    int last_chg[3], t0[3];

    // observed event bookkeeping
    int cnt_click[3], cnt_lp[3], cnt_press[3], rise_at[3], click_at[3], lp_at[3];
    bit prev_press[3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic set_p(input logic v);
        p = v;
        btn_a = v;
        btn_b = ~v;
        btn_c = v;
    endtask

    function automatic logic bval(input int k);
        case (k)
            0: return btn_a;
            1: return btn_b;
            default: return btn_c;
        endcase
    endfunction

    function automatic logic [2:0] obs(input int k);
        case (k)
            0: return {click_a, lp_a, press_a};
            1: return {click_b, lp_b, press_b};
            default: return {click_c, lp_c, press_c};
        endcase
    endfunction

    function automatic logic [2:0] expv(input int k);
        return {e_click[k] ? COL[k] : ~COL[k], e_lp[k] ? COL[k] : ~COL[k], e_press[k]};
    endfunction

    // One rising edge of model k, using the inputs as they stand at that edge.
    task automatic mdl_step(input int k);
        bit r, seen, dbv;
        r = bval(k) ~^ BIL[k];
        if (reset) begin
            s1[k] = 0; s2[k] = 0; db[k] = 0; prev_seen[k] = 0; last_chg[k] = n;
            pressed[k] = 0; held_long[k] = 0;
            e_click[k] = 0; e_lp[k] = 0; e_press[k] = 0;
            return;
        end
        seen = s2[k];
        dbv  = (DBT[k] == 0) ? s2[k] : db[k];
        e_click[k] = 0;
        e_lp[k] = 0;
        if (!pressed[k]) begin
            if (dbv) begin
                pressed[k] = 1;
                t0[k] = n;
                if (LPT[k] == 0) begin held_long[k] = 1; e_lp[k] = 1; end
            end
        end else if (!held_long[k]) begin
            if (n - t0[k] == LPT[k]) begin held_long[k] = 1; e_lp[k] = 1; end
            else if (!dbv) begin pressed[k] = 0; e_click[k] = 1; end
        end else if (!dbv) begin
            pressed[k] = 0;
            held_long[k] = 0;
        end
        e_press[k] = pressed[k];
        if (DBT[k] > 0) begin
            if (seen != prev_seen[k]) last_chg[k] = n;
            prev_seen[k] = seen;
            // accept a level only after DBT consecutive cycles of seeing it
            if (seen != db[k] && n - last_chg[k] + 1 == DBT[k]) db[k] = seen;
        end
        s2[k] = s1[k];
        s1[k] = r;
    endtask

    task automatic clr_cnt();
        for (int k = 0; k < 3; k++) begin
            cnt_click[k] = 0; cnt_lp[k] = 0; cnt_press[k] = 0;
            rise_at[k] = -1; click_at[k] = -1; lp_at[k] = -1;
        end
    endtask

    task automatic cyc();
        logic [2:0] o;
        @(posedge clk);
        n++;
        for (int k = 0; k < 3; k++) mdl_step(k);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            o = obs(k);
            chk($sformatf("cycle_out%0d", k), 32'(o), 32'(expv(k)));
            if (o[2] == COL[k]) begin cnt_click[k]++; click_at[k] = n; end
            if (o[1] == COL[k]) begin cnt_lp[k]++; lp_at[k] = n; end
            if (o[0]) cnt_press[k]++;
            if (o[0] && !prev_press[k]) rise_at[k] = n;
            prev_press[k] = o[0];
        end
        if (errors > 40) finish_run();
    endtask

    initial begin
        int rel_n, lat, nb, hold;
        logic [2:0] o;
        set_p(1'b0);
        reset = 1'b1;
        clr_cnt();
        repeat (5) cyc();
        chk("reset_idle_a", 32'(obs(0)), 32'(3'b000));
        chk("reset_idle_b", 32'(obs(1)), 32'(3'b110));
        chk("reset_idle_c", 32'(obs(2)), 32'(3'b000));
        reset = 1'b0;
        repeat (20) cyc();

        // glitch just shorter than the debounce time
        clr_cnt();
        set_p(1'b1); repeat (999) cyc();
        set_p(1'b0); repeat (1500) cyc();
        chk("glitch_press_a", cnt_press[0], 0);
        chk("glitch_click_a", cnt_click[0], 0);
        chk("glitch_lp_a", cnt_lp[0], 0);

        // short press
        clr_cnt();
        set_p(1'b1); repeat (2000) cyc();
        rel_n = n;
        set_p(1'b0); repeat (2000) cyc();
        chk("short_click_a", cnt_click[0], 1);
        chk("short_lp_a", cnt_lp[0], 0);
        chk("short_press_len_a", cnt_press[0], 2000);
        chk("short_click_dly_a", click_at[0] - rel_n, 1003);
        chk("short_click_b", cnt_click[1], 1);

        // long press
        clr_cnt();
        set_p(1'b1); repeat (8000) cyc();
        set_p(1'b0); repeat (2000) cyc();
        chk("long_lp_a", cnt_lp[0], 1);
        chk("long_click_a", cnt_click[0], 0);
        chk("long_lp_dly_a", lp_at[0] - rise_at[0], 5000);
        chk("long_lp_b", cnt_lp[1], 1);

        // release one cycle before the threshold, then exactly at it
        clr_cnt();
        set_p(1'b1); repeat (4999) cyc();
        set_p(1'b0); repeat (2000) cyc();
        chk("edge_click_a", cnt_click[0], 1);
        chk("edge_lp_a", cnt_lp[0], 0);
        clr_cnt();
        set_p(1'b1); repeat (5000) cyc();
        set_p(1'b0); repeat (2000) cyc();
        chk("tie_click_a", cnt_click[0], 0);
        chk("tie_lp_a", cnt_lp[0], 1);

        // reset in the middle of a hold
        clr_cnt();
        set_p(1'b1); repeat (3000) cyc();
        reset = 1'b1; repeat (2) cyc();
        o = obs(0);
        chk("rst_hold_press_a", 32'(o[0]), 0);
        reset = 1'b0;
        repeat (8000) cyc();
        set_p(1'b0); repeat (2000) cyc();
        chk("rst_hold_lp_a", cnt_lp[0], 1);
        chk("rst_hold_click_a", cnt_click[0], 0);
        chk("rst_hold_lp_dly_a", lp_at[0] - rise_at[0], 5000);

        // single-cycle press on the unfiltered, zero-hold configuration
        clr_cnt();
        lat = 0;
        set_p(1'b1);
        do begin
            cyc();
            lat++;
            if (lat == 1) set_p(1'b0);
            o = obs(2);
        end while (!o[0] && lat < 10);
        chk("c_press_latency", lat, 3);
        repeat (50) cyc();
        chk("c_lp_count", cnt_lp[2], 1);
        chk("c_click_count", cnt_click[2], 0);
        repeat (1500) cyc();

        // random bounce bursts followed by random holds
        for (int s = 0; s < 6; s++) begin
            nb = $urandom_range(2, 10);
            for (int b = 0; b < nb; b++) begin
                set_p(~p);
                repeat ($urandom_range(1, 400)) cyc();
            end
            set_p(1'($urandom_range(0, 1)));
            hold = $urandom_range(200, 4500);
            if ($urandom_range(0, 3) == 0) begin
                repeat (hold / 2) cyc();
                reset = 1'b1; repeat (2) cyc(); reset = 1'b0;
                repeat (hold / 2) cyc();
            end else begin
                repeat (hold) cyc();
            end
        end
        set_p(1'b0);
        repeat (1500) cyc();
        finish_run();
    end

endmodule
